// File: rtl/sort_sequencer_if.sv
// Stream and sorter-port bundle for sort_sequencer.
// master = controller side, slave = producer/consumer/sorter side.
interface sort_sequencer_if #(
   parameter int W = 4
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         busy;
   logic         sort_en;
   logic [W-1:0] sort_a;
   logic [W-1:0] sort_b;
   logic [W-1:0] sort_lo;
   logic [W-1:0] sort_hi;

   modport master (
      input  in_valid, in_data, out_ready, sort_lo, sort_hi,
      output in_ready, out_valid, out_data, busy,
      output sort_en, sort_a, sort_b
   );

   modport slave (
      output in_valid, in_data, out_ready, sort_lo, sort_hi,
      input  in_ready, out_valid, out_data, busy,
      input  sort_en, sort_a, sort_b
   );
endinterface

// File: rtl/sort_sequencer.sv
// Odd-even transposition sorter driving one shared registered min/max unit.
// SORT_EARLY_EXIT_EN: stop after two consecutive swap-free phases.
module sort_sequencer #(
   parameter int N = 8,
   parameter int W = 4
) (
   input logic clk,
   input logic rstN,
   sort_sequencer_if.master bus
);
   localparam int AW = $clog2(N);
   localparam logic [AW-1:0] LAST = AW'(N - 1);
   localparam logic [AW-1:0] HALF = AW'(N / 2);

   typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

   state_t         state, state_n;
   logic [W-1:0]   mem [N];
   logic [AW-1:0]  wr_idx, wr_n;
   logic [AW-1:0]  rd_idx, rd_n;
   logic [AW-1:0]  p, p_n;
   logic [AW-1:0]  c, c_n;
   logic [AW-1:0]  ii, npairs;
   logic [AW-1:0]  wb_i;
   logic           wb_pend;
   logic           rdy_q;
   logic           done;
   logic           in_rdy, out_vld, bsy, s_en;
   logic [W-1:0]   o_data, s_a, s_b;
`ifdef SORT_EARLY_EXIT_EN
   logic [W-1:0]   wb_a;
   logic           swp, prev_clean, clean;
`endif

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.out_data  = o_data;
   assign bus.busy      = bsy;
   assign bus.sort_en   = s_en;
   assign bus.sort_a    = s_a;
   assign bus.sort_b    = s_b;

   // pair start index and pair count for the current phase
   always_comb begin
      npairs = p[0] ? HALF - AW'(1) : HALF;
      ii     = AW'({c, p[0]});
`ifdef SORT_EARLY_EXIT_EN
      clean = !swp && !(wb_pend && bus.sort_lo != wb_a);
      done  = (p == LAST) || (clean && prev_clean);
`else
      done  = (p == LAST);
`endif
   end

   // next-state, counters and stream/sorter outputs
   always_comb begin
      state_n = state;
      wr_n    = wr_idx;
      rd_n    = rd_idx;
      p_n     = p;
      c_n     = c;
      in_rdy  = 1'b0;
      out_vld = 1'b0;
      o_data  = '0;
      bsy     = 1'b0;
      s_en    = 1'b0;
      s_a     = '0;
      s_b     = '0;
      unique case (state)
         LOAD: begin
            in_rdy = rdy_q;
            if (bus.in_valid && rdy_q) begin
               wr_n = wr_idx + AW'(1);
               if (wr_idx == LAST) begin
                  wr_n    = '0;
                  p_n     = '0;
                  c_n     = '0;
                  state_n = SORT;
               end
            end
         end
         SORT: begin
            bsy = 1'b1;
            if (c != npairs) begin
               s_en = 1'b1;
               s_a  = mem[ii];
               s_b  = mem[ii + AW'(1)];
               c_n  = c + AW'(1);
            end else begin
               c_n = '0;
               p_n = p + AW'(1);
               if (done) begin
                  p_n     = '0;
                  state_n = DRAIN;
               end
            end
         end
         DRAIN: begin
            out_vld = 1'b1;
            o_data  = mem[rd_idx];
            if (bus.out_ready) begin
               rd_n = rd_idx + AW'(1);
               if (rd_idx == LAST) begin
                  rd_n    = '0;
                  state_n = LOAD;
               end
            end
         end
         default: state_n = LOAD;
      endcase
   end

   // state, counters and writeback tracking
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state   <= LOAD;
         wr_idx  <= '0;
         rd_idx  <= '0;
         p       <= '0;
         c       <= '0;
         wb_pend <= 1'b0;
         wb_i    <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state   <= state_n;
         wr_idx  <= wr_n;
         rd_idx  <= rd_n;
         p       <= p_n;
         c       <= c_n;
         wb_pend <= s_en;
         wb_i    <= ii;
         rdy_q   <= 1'b1;
      end
   end

`ifdef SORT_EARLY_EXIT_EN
   // per-phase swap detection for early termination
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wb_a       <= '0;
         swp        <= 1'b0;
         prev_clean <= 1'b0;
      end else begin
         wb_a <= s_a;
         if (state != SORT) begin
            swp        <= 1'b0;
            prev_clean <= 1'b0;
         end else if (c == npairs) begin
            swp        <= 1'b0;
            prev_clean <= clean;
         end else if (wb_pend && bus.sort_lo != wb_a) begin
            swp <= 1'b1;
         end
      end
   end
`endif

   // buffer: loads in LOAD, sorter writebacks in SORT
   always_ff @(posedge clk) begin
      if (in_rdy && bus.in_valid)
         mem[wr_idx] <= bus.in_data;
      if (state == SORT && wb_pend) begin
         mem[wb_i]            <= bus.sort_lo;
         mem[wb_i + AW'(1)]   <= bus.sort_hi;
      end
   end
endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer (N=8, W=4) with a registered
// min/max sorter model and immediate-assertion checks.
module tb_sort_sequencer;
   typedef logic [3:0] blk_t [8];

   logic clk = 1'b0;
   logic rstN = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   bcnt = 0;
   logic [3:0] slo = '0;
   logic [3:0] shi = '0;

   sort_sequencer_if #(.W(4)) bus ();

   sort_sequencer #(.N(8), .W(4)) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // external registered two-sorter
   always @(posedge clk) begin
      slo <= (bus.sort_a < bus.sort_b) ? bus.sort_a : bus.sort_b;
      shi <= (bus.sort_a < bus.sort_b) ? bus.sort_b : bus.sort_a;
   end
   assign bus.sort_lo = slo;
   assign bus.sort_hi = shi;

   // busy cycle counter
   always @(posedge clk) if (bus.busy) bcnt <= bcnt + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0d want %0d", tag, obs, exp);
      end
   endtask

   // idle-operand and in_ready invariants
   always @(negedge clk) begin
      if (rstN && !bus.sort_en)
         chk("sort_ab_idle", {bus.sort_a, bus.sort_b}, 0);
      if (rstN && (bus.busy || bus.out_valid))
         chk("in_ready_low", bus.in_ready, 0);
   end

   task automatic load(input blk_t v, input int gap);
      int t;
      for (int k = 0; k < 8; k++) begin
         if (gap > 0 && k[0]) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = v[k];
         t = 0;
         while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
         end
         chk("load_tmo", int'(t < 200), 1);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
   endtask

   task automatic drain(input string tag, input blk_t e, input int stall);
      int t;
      logic [3:0] d;
      for (int k = 0; k < 8; k++) begin
         t = 0;
         while (!bus.out_valid && t < 200) begin
            @(negedge clk);
            t++;
         end
         chk("drain_tmo", int'(t < 200), 1);
         if (stall != 0) begin
            bus.out_ready = 1'b0;
            d = bus.out_data;
            @(negedge clk);
            chk("stall_hold", bus.out_data, d);
         end
         chk(tag, bus.out_data, e[k]);
         bus.out_ready = 1'b1;
         @(negedge clk);
      end
      bus.out_ready = 1'b0;
      chk("valid_drop", bus.out_valid, 0);
   endtask

   task automatic zero_outs(input string tag);
      chk(tag, {bus.in_ready, bus.out_valid, bus.out_data, bus.busy,
                bus.sort_en, bus.sort_a, bus.sort_b}, 0);
   endtask

   initial begin
      blk_t v, e;
      int sorted_busy;
`ifdef SORT_EARLY_EXIT_EN
      sorted_busy = 9;
`else
      sorted_busy = 36;
`endif
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      zero_outs("reset_outs");
      rstN = 1'b1;

      v = '{7, 3, 5, 1, 6, 2, 4, 0};
      e = '{0, 1, 2, 3, 4, 5, 6, 7};
      bcnt = 0;
      load(v, 0);
      drain("mixed", e, 0);
      chk("busy_mixed", bcnt, 36);

      v = '{0, 1, 2, 3, 4, 5, 6, 7};
      bcnt = 0;
      load(v, 0);
      drain("sorted", e, 0);
      chk("busy_sorted", bcnt, sorted_busy);

      v = '{15, 14, 13, 12, 11, 10, 9, 8};
      e = '{8, 9, 10, 11, 12, 13, 14, 15};
      bcnt = 0;
      load(v, 0);
      drain("reverse", e, 0);
      chk("busy_reverse", bcnt, 36);

      v = '{5, 5, 5, 5, 0, 0, 15, 15};
      e = '{0, 0, 5, 5, 5, 5, 15, 15};
      load(v, 0);
      drain("dups", e, 0);

      v = '{9, 1, 8, 2, 7, 3, 6, 4};
      e = '{1, 2, 3, 4, 6, 7, 8, 9};
      load(v, 2);
      drain("stalled", e, 1);

      v = '{7, 3, 5, 1, 6, 2, 4, 0};
      load(v, 0);
      repeat (10) @(negedge clk);
      chk("mid_sort_busy", bus.busy, 1);
      rstN = 1'b0;
      #1;
      zero_outs("abort_outs");
      @(negedge clk);
      rstN = 1'b1;
      v = '{3, 2, 1, 0, 7, 6, 5, 4};
      e = '{0, 1, 2, 3, 4, 5, 6, 7};
      load(v, 0);
      drain("after_reset", e, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
